// File: rtl/gpi_debounce.sv
// Two-flop synchroniser plus per-bit integrating debounce for general-purpose inputs.
// Optional rise/fall event pulses are built when GPI_DEBOUNCE_EDGE_EN is defined.
module gpi_debounce #(
  parameter int unsigned      Width          = 8,
  parameter int unsigned      DebounceCycles = 50000,
  parameter logic [Width-1:0] ResetValue     = '0
) (
  input  logic             clk_sys_i,
  input  logic             rst_sys_ni,
  input  logic [Width-1:0] raw_i,
  output logic [Width-1:0] gp_o,
  output logic [Width-1:0] rise_o,
  output logic [Width-1:0] fall_o
);

  localparam int unsigned           CntWidth = $clog2(DebounceCycles + 1);
  localparam logic [CntWidth-1:0]   CntLast  = CntWidth'(DebounceCycles - 1);

  logic [Width-1:0]    s1_q, s2_q;
  logic [Width-1:0]    gp_q, gp_d;
  logic [CntWidth-1:0] cnt_q [Width];
  logic [CntWidth-1:0] cnt_d [Width];

  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk_sys_i or negedge rst_sys_ni) begin
    if (!rst_sys_ni) begin
      s1_q <= ResetValue;
      s2_q <= ResetValue;
    end else begin
      s1_q <= raw_i;
      s2_q <= s1_q;
    end
  end

  // A differing level must be seen DebounceCycles times in a row; any agreement restarts the count.
  always_comb begin
    // NOTE: defaults first so no path leaves a combinational output unassigned (no latches).
    gp_d = gp_q;
    for (int i = 0; i < int'(Width); i++) begin
      cnt_d[i] = '0;
      if (s2_q[i] != gp_q[i]) begin
        if (cnt_q[i] == CntLast) begin
          gp_d[i] = s2_q[i];
        end else begin
          cnt_d[i] = cnt_q[i] + CntWidth'(1);
        end
      end
    end
  end

  // NOTE: the counters are a handful of flops, not a RAM, so resetting every entry is intended.
  always_ff @(posedge clk_sys_i or negedge rst_sys_ni) begin
    if (!rst_sys_ni) begin
      gp_q <= ResetValue;
      for (int i = 0; i < int'(Width); i++) begin
        cnt_q[i] <= '0;
      end
    end else begin
      gp_q <= gp_d;
      for (int i = 0; i < int'(Width); i++) begin
        cnt_q[i] <= cnt_d[i];
      end
    end
  end

  assign gp_o = gp_q;

`ifdef GPI_DEBOUNCE_EDGE_EN
  logic [Width-1:0] rise_q, fall_q;

  // Pulses are registered from the next-state compare so they line up with the gp_o change.
  always_ff @(posedge clk_sys_i or negedge rst_sys_ni) begin
    if (!rst_sys_ni) begin
      rise_q <= '0;
      fall_q <= '0;
    end else begin
      rise_q <= gp_d & ~gp_q;
      fall_q <= ~gp_d & gp_q;
    end
  end

  assign rise_o = rise_q;
  assign fall_o = fall_q;
`else
  assign rise_o = '0;
  assign fall_o = '0;
`endif

endmodule

// File: tb/tb_gpi_debounce.sv
// Self-checking bench for gpi_debounce: directed scenarios plus randomized pin activity,
// all compared against a sliding-window reference model of the debounce rule.
module tb_gpi_debounce;

  localparam int         W  = 8;
  localparam int         D  = 4;
  localparam logic [7:0] RV = 8'h00;
`ifdef GPI_DEBOUNCE_EDGE_EN
  localparam bit EDGE_EN = 1'b1;
`else
  localparam bit EDGE_EN = 1'b0;
`endif

  logic         clk;
  logic         rst_n;
  logic [W-1:0] raw;
  logic [W-1:0] gp, rise, fall;

  int total = 0;
  int bad   = 0;

  gpi_debounce #(
    .Width         (W),
    .DebounceCycles(D),
    .ResetValue    (RV)
  ) dut (
    .clk_sys_i (clk),
    .rst_sys_ni(rst_n),
    .raw_i     (raw),
    .gp_o      (gp),
    .rise_o    (rise),
    .fall_o    (fall)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference model: hist[k] is the pin level sampled k edges ago. The synchronised level the
  // design judges at an edge is hist[2..]; a bit flips once its last D judged levels all differ.
  logic [7:0] hist [D+2];
  logic [7:0] gp_m, rise_m, fall_m, nxt_m;
  bit         all_diff;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int k = 0; k < D + 2; k++) hist[k] = RV;
      gp_m   = RV;
      rise_m = '0;
      fall_m = '0;
    end else begin
      for (int k = D + 1; k > 0; k--) hist[k] = hist[k-1];
      hist[0] = raw;
      nxt_m   = gp_m;
      for (int b = 0; b < W; b++) begin
        all_diff = 1'b1;
        for (int k = 2; k < D + 2; k++)
          if (hist[k][b] == gp_m[b]) all_diff = 1'b0;
        if (all_diff) nxt_m[b] = ~gp_m[b];
      end
      rise_m = EDGE_EN ? (nxt_m & ~gp_m) : 8'h00;
      fall_m = EDGE_EN ? (~nxt_m & gp_m) : 8'h00;
      gp_m   = nxt_m;
    end
  end

  task automatic apply_reset(input logic [7:0] r);
    @(negedge clk);
    rst_n = 1'b0;
    raw   = r;
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic test_reset;
    @(negedge clk);
    rst_n = 1'b0;
    raw   = 8'hFF;
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      total++;
      if ({gp, rise, fall} !== 24'h0) begin
        bad++;
        $display("FAIL reset_hold cyc=%0d got gp=%h rise=%h fall=%h want all 00", c, gp, rise, fall);
      end
    end
    rst_n = 1'b1;
    for (int e = 1; e <= 8; e++) begin
      @(negedge clk);
      total++;
      if ({gp, rise, fall} !== {gp_m, rise_m, fall_m}) begin
        bad++;
        $display("FAIL reset_release edge=%0d got %h/%h/%h want %h/%h/%h", e, gp, rise, fall, gp_m, rise_m, fall_m);
      end
      if (e == 5 || e == 6) begin
        total++;
        if (gp !== ((e == 6) ? 8'hFF : 8'h00) || rise !== ((e == 6 && EDGE_EN) ? 8'hFF : 8'h00)) begin
          bad++;
          $display("FAIL reset_release_edge%0d got gp=%h rise=%h", e, gp, rise);
        end
      end
    end
  endtask

  task automatic test_clean_step;
    apply_reset(8'h00);
    raw = 8'h01;
    for (int e = 1; e <= 9; e++) begin
      @(negedge clk);
      total++;
      if ({gp, rise, fall} !== {gp_m, rise_m, fall_m}) begin
        bad++;
        $display("FAIL clean_step edge=%0d got %h/%h/%h want %h/%h/%h", e, gp, rise, fall, gp_m, rise_m, fall_m);
      end
      if (e == 5 || e == 6) begin
        total++;
        if (gp !== ((e == 6) ? 8'h01 : 8'h00) || rise !== ((e == 6 && EDGE_EN) ? 8'h01 : 8'h00)) begin
          bad++;
          $display("FAIL clean_step_edge%0d got gp=%h rise=%h", e, gp, rise);
        end
      end
    end
  endtask

  task automatic test_glitch;
    apply_reset(8'h00);
    raw = 8'h08;
    for (int e = 1; e <= 12; e++) begin
      @(negedge clk);
      if (e == 3) raw = 8'h00;
      total++;
      if ({gp, rise, fall} !== 24'h0 || {gp, rise, fall} !== {gp_m, rise_m, fall_m}) begin
        bad++;
        $display("FAIL glitch_reject edge=%0d got %h/%h/%h want 00/00/00", e, gp, rise, fall);
      end
    end
    raw = 8'h08;
    for (int e = 1; e <= 14; e++) begin
      @(negedge clk);
      if (e == 4) raw = 8'h00;
      total++;
      if ({gp, rise, fall} !== {gp_m, rise_m, fall_m}) begin
        bad++;
        $display("FAIL glitch_accept edge=%0d got %h/%h/%h want %h/%h/%h", e, gp, rise, fall, gp_m, rise_m, fall_m);
      end
      if (e == 6) begin
        total++;
        if (gp !== 8'h08 || rise !== (EDGE_EN ? 8'h08 : 8'h00)) begin
          bad++;
          $display("FAIL glitch_accept_edge6 got gp=%h rise=%h want gp=08", gp, rise);
        end
      end
    end
  endtask

  task automatic test_bounce;
    int pulses = 0;
    apply_reset(8'h00);
    for (int c = 0; c < 16; c++) begin
      raw = (c < 5) ? ((c % 2 == 0) ? 8'h02 : 8'h00) : 8'h02;
      @(negedge clk);
      if (rise[1]) pulses++;
      total++;
      if ({gp, rise, fall} !== {gp_m, rise_m, fall_m}) begin
        bad++;
        $display("FAIL bounce cyc=%0d got %h/%h/%h want %h/%h/%h", c, gp, rise, fall, gp_m, rise_m, fall_m);
      end
      if (c == 8 || c == 9) begin
        total++;
        if (gp !== ((c == 9) ? 8'h02 : 8'h00)) begin
          bad++;
          $display("FAIL bounce_edge cyc=%0d got gp=%h", c, gp);
        end
      end
    end
    total++;
    if (pulses !== (EDGE_EN ? 1 : 0)) begin
      bad++;
      $display("FAIL bounce_pulse_count got %0d want %0d", pulses, EDGE_EN ? 1 : 0);
    end
  endtask

  task automatic test_independent;
    apply_reset(8'h00);
    for (int t = 0; t < 18; t++) begin
      if (t == 0)  raw = 8'h01;
      if (t == 2)  raw = 8'h81;
      if (t == 10) raw = 8'h00;
      @(negedge clk);
      total++;
      if ({gp, rise, fall} !== {gp_m, rise_m, fall_m}) begin
        bad++;
        $display("FAIL independent t=%0d got %h/%h/%h want %h/%h/%h", t, gp, rise, fall, gp_m, rise_m, fall_m);
      end
      if (t == 5 || t == 7) begin
        total++;
        if (gp !== ((t == 5) ? 8'h01 : 8'h81)) begin
          bad++;
          $display("FAIL independent_rise t=%0d got gp=%h", t, gp);
        end
      end
      if (t == 15) begin
        total++;
        if (gp !== 8'h00 || fall !== (EDGE_EN ? 8'h81 : 8'h00) || rise !== 8'h00) begin
          bad++;
          $display("FAIL independent_fall got gp=%h fall=%h rise=%h", gp, fall, rise);
        end
      end
    end
  endtask

  task automatic test_reset_mid;
    apply_reset(8'h00);
    raw = 8'h04;
    repeat (4) @(negedge clk);
    rst_n = 1'b0;
    for (int c = 0; c < 2; c++) begin
      @(negedge clk);
      total++;
      if ({gp, rise, fall} !== 24'h0) begin
        bad++;
        $display("FAIL reset_mid_hold cyc=%0d got %h/%h/%h want 00/00/00", c, gp, rise, fall);
      end
    end
    rst_n = 1'b1;
    for (int e = 1; e <= 8; e++) begin
      @(negedge clk);
      total++;
      if ({gp, rise, fall} !== {gp_m, rise_m, fall_m}) begin
        bad++;
        $display("FAIL reset_mid edge=%0d got %h/%h/%h want %h/%h/%h", e, gp, rise, fall, gp_m, rise_m, fall_m);
      end
      if (e == 5 || e == 6) begin
        total++;
        if (gp !== ((e == 6) ? 8'h04 : 8'h00)) begin
          bad++;
          $display("FAIL reset_mid_edge%0d got gp=%h", e, gp);
        end
      end
    end
  endtask

  task automatic test_random;
    apply_reset(8'h00);
    for (int c = 0; c < 3000; c++) begin
      for (int b = 0; b < W; b++)
        if ($urandom_range(0, 5) == 0) raw[b] = ~raw[b];
      if ($urandom_range(0, 499) == 0) rst_n = 1'b0;
      else rst_n = 1'b1;
      @(negedge clk);
      total++;
      if ({gp, rise, fall} !== {gp_m, rise_m, fall_m} || (rise & fall) !== 8'h00) begin
        bad++;
        $display("FAIL random cyc=%0d got %h/%h/%h want %h/%h/%h", c, gp, rise, fall, gp_m, rise_m, fall_m);
      end
    end
    rst_n = 1'b1;
  endtask

  initial begin
    rst_n = 1'b0;
    raw   = 8'h00;
    test_reset();
    test_clean_step();
    test_glitch();
    test_bounce();
    test_independent();
    test_reset_mid();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
